// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Holds the default widths, the arbitration state enum and the x0 index.
package rf_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int X0         = 0;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  // Next round-robin position after v, wrapping at n.
  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping, returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int cand;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && !any_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = ID_W'(cand);
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing the register file write port and read port 1,
// with a per-requester lock for atomic read-modify-write sequences.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         rf_write_reg,
  output logic                      rf_reg_write,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [ADDR_W-1:0]         rf_read_reg1,
  input  logic [DATA_W-1:0]         rf_read_data1
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]   rd_reg_q;
  logic                rsp_valid_q;
  logic                rsp_zero_q;
  logic [ID_W-1:0]     rsp_id_q;

  logic [NUM_REQ-1:0]  arb_req;
  logic [ID_W-1:0]     arb_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gid;
  logic                fire;
  logic                rd_fire;
  logic                sel_we;
  logic                sel_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // While locked, only the owner may compete; starting the search at the
  // owner makes it the sole candidate.
  always_comb begin
    arb_req = req_valid;
    arb_ptr = ptr_q;
    if (state_q == LOCKED) begin
      arb_req = req_valid & (NUM_REQ'(1) << owner_q);
      arb_ptr = owner_q;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i   (arb_req),
    .ptr_i   (arb_ptr),
    .en_i    (rst_n),
    .grant_o (grant),
    .idx_o   (gid),
    .any_o   (fire)
  );

  assign req_ready = grant;
  assign sel_we    = req_we[gid];
  assign sel_lock  = req_lock[gid];
  assign sel_addr  = req_addr[int'(gid)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(gid)*DATA_W +: DATA_W];
  assign rd_fire   = fire & ~sel_we;

  assign rf_reg_write  = fire & sel_we & (sel_addr != ADDR_W'(X0));
  assign rf_write_reg  = sel_addr;
  assign rf_write_data = sel_wdata;
  // Idle cycles keep the last read index to avoid toggling the read decoder.
  assign rf_read_reg1  = rd_fire ? sel_addr : rd_reg_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_zero_q ? '0 : rf_read_data1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (fire) begin
      unique case (state_q)
        IDLE: begin
          ptr_d = ID_W'(wrap_inc(32'(gid), NUM_REQ));
          if (sel_lock) begin
            state_d = LOCKED;
            owner_d = gid;
          end
        end
        LOCKED: begin
          if (!sel_lock) begin
            state_d = IDLE;
            ptr_d   = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_zero_q  <= 1'b0;
      rd_reg_q    <= '0;
    end else begin
      rsp_valid_q <= rd_fire;
      rd_reg_q    <= rf_read_reg1;
      if (rd_fire) begin
        rsp_id_q   <= gid;
        rsp_zero_q <= (sel_addr == ADDR_W'(X0));
      end
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: per-cycle vector table plus a
// hand-written reset-during-lock sequence, with a read-response scoreboard.
module tb_rf_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   rf_write_reg, rf_read_reg1;
  logic            rf_reg_write;
  logic [DW-1:0]   rf_write_data, rf_read_data1;

  always #5 clk = ~clk;

  rf_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_rdata     (rsp_rdata),
    .rf_write_reg  (rf_write_reg),
    .rf_reg_write  (rf_reg_write),
    .rf_write_data (rf_write_data),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_data1 (rf_read_data1)
  );

  // Register file model: registered read port, write commits at the edge.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;
    rf_read_data1 <= rf_mem[rf_read_reg1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.data));
      end
    end
  end

  typedef struct {
    logic [N-1:0]    valid;
    logic [N-1:0]    we;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    exp_ready;
    logic            exp_rw;
    logic [AW-1:0]   exp_wreg;
    logic [DW-1:0]   exp_wdata;
    logic            exp_rd;
    logic [AW-1:0]   exp_rreg;
    logic [DW-1:0]   exp_rsp;
  } vec_t;

  function automatic logic [N*AW-1:0] a3(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] d3(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                         input logic [DW-1:0] d2);
    return {d2, d1, d0};
  endfunction

  function automatic logic [IW-1:0] oh2idx(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return IW'(i);
    return '0;
  endfunction

  localparam logic [DW-1:0] DA = 32'hAAAA_0001;
  localparam logic [DW-1:0] DB = 32'hBBBB_0002;
  localparam logic [DW-1:0] DC = 32'hCCCC_0003;
  localparam logic [DW-1:0] DE = 32'hDEAD_BEEF;

  vec_t vecs[16];

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    req_valid = v;
    req_we    = w;
    req_lock  = l;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic push_rsp(input logic [IW-1:0] id, input logic [DW-1:0] data);
    rsp_t e;
    e.id   = id;
    e.data = data;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA5A5_0000 + DW'(i);
    rf_mem[0] = 32'hBAD0_BAD0;

    //           valid   we      lock    addr         wdata              ready  rw    wreg  wdata  rd    rreg  rsp
    vecs[0]  = '{3'b111, 3'b111, 3'b000, a3(1,2,3),   d3(DA,DB,DC),      3'b001, 1'b1, 5'd1,  DA,    1'b0, 5'd0, '0};
    vecs[1]  = '{3'b111, 3'b111, 3'b000, a3(1,2,3),   d3(DA,DB,DC),      3'b010, 1'b1, 5'd2,  DB,    1'b0, 5'd0, '0};
    vecs[2]  = '{3'b111, 3'b111, 3'b000, a3(1,2,3),   d3(DA,DB,DC),      3'b100, 1'b1, 5'd3,  DC,    1'b0, 5'd0, '0};
    vecs[3]  = '{3'b111, 3'b111, 3'b000, a3(1,2,3),   d3(DA,DB,DC),      3'b001, 1'b1, 5'd1,  DA,    1'b0, 5'd0, '0};
    vecs[4]  = '{3'b010, 3'b010, 3'b000, a3(0,5,0),   d3('0,DE,'0),      3'b010, 1'b1, 5'd5,  DE,    1'b0, 5'd0, '0};
    vecs[5]  = '{3'b100, 3'b000, 3'b000, a3(0,0,5),   d3('0,'0,'0),      3'b100, 1'b0, 5'd0,  '0,    1'b1, 5'd5, DE};
    vecs[6]  = '{3'b001, 3'b001, 3'b000, a3(0,0,0),   d3(32'h1234,'0,'0),3'b001, 1'b0, 5'd0,  '0,    1'b0, 5'd5, '0};
    vecs[7]  = '{3'b001, 3'b000, 3'b000, a3(0,0,0),   d3('0,'0,'0),      3'b001, 1'b0, 5'd0,  '0,    1'b1, 5'd0, '0};
    vecs[8]  = '{3'b100, 3'b100, 3'b000, a3(0,0,3),   d3('0,'0,DC),      3'b100, 1'b1, 5'd3,  DC,    1'b0, 5'd0, '0};
    vecs[9]  = '{3'b111, 3'b110, 3'b001, a3(7,9,10),  d3('0,32'h11,32'h22), 3'b001, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hA5A5_0007};
    vecs[10] = '{3'b110, 3'b110, 3'b000, a3(7,9,10),  d3('0,32'h11,32'h22), 3'b000, 1'b0, 5'd0, '0, 1'b0, 5'd7, '0};
    vecs[11] = '{3'b111, 3'b111, 3'b000, a3(7,9,10),  d3(32'h77,32'h11,32'h22), 3'b001, 1'b1, 5'd7, 32'h77, 1'b0, 5'd7, '0};
    vecs[12] = '{3'b110, 3'b110, 3'b000, a3(7,9,10),  d3(32'h77,32'h11,32'h22), 3'b010, 1'b1, 5'd9, 32'h11, 1'b0, 5'd7, '0};
    vecs[13] = '{3'b100, 3'b100, 3'b000, a3(7,9,10),  d3(32'h77,32'h11,32'h22), 3'b100, 1'b1, 5'd10, 32'h22, 1'b0, 5'd7, '0};
    vecs[14] = '{3'b010, 3'b000, 3'b000, a3(0,7,0),   d3('0,'0,'0),      3'b010, 1'b0, 5'd0,  '0,    1'b1, 5'd7, 32'h77};
    vecs[15] = '{3'b000, 3'b000, 3'b000, a3(0,0,0),   d3('0,'0,'0),      3'b000, 1'b0, 5'd0,  '0,    1'b0, 5'd7, '0};

    // Reset state, with requests already asserted to show ready is held low.
    drive(3'b111, 3'b111, 3'b000, a3(1,2,3), d3(DA,DB,DC));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_reg_write", 64'(rf_reg_write), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].lock, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_reg_write", i), 64'(rf_reg_write), 64'(vecs[i].exp_rw));
      if (vecs[i].exp_rw) begin
        check($sformatf("v%0d_write_reg", i), 64'(rf_write_reg), 64'(vecs[i].exp_wreg));
        check($sformatf("v%0d_write_data", i), 64'(rf_write_data), 64'(vecs[i].exp_wdata));
      end
      check($sformatf("v%0d_read_reg1", i), 64'(rf_read_reg1), 64'(vecs[i].exp_rreg));
      if (vecs[i].exp_rd) push_rsp(oh2idx(vecs[i].exp_ready), vecs[i].exp_rsp);
      next_cycle();
    end
    check("x0_untouched", 64'(rf_mem[0]), 64'(32'hBAD0_BAD0));

    // Lock by requester 1, a second locked read, then reset mid-lock with
    // that second response still in flight.
    drive(3'b010, 3'b000, 3'b010, a3(0,5,0), d3('0,'0,'0));
    @(negedge clk);
    check("rl_lock_grant", 64'(req_ready), 64'(3'b010));
    push_rsp(IW'(1), DE);
    next_cycle();
    drive(3'b111, 3'b101, 3'b010, a3(1,3,2), d3(DA,'0,DC));
    @(negedge clk);
    check("rl_locked_grant", 64'(req_ready), 64'(3'b010));
    next_cycle();
    rst_n = 1'b0;
    drive(3'b111, 3'b111, 3'b000, a3(1,2,3), d3(DA,DB,DC));
    @(negedge clk);
    check("rl_in_reset_ready", 64'(req_ready), 64'(0));
    check("rl_in_reset_reg_write", 64'(rf_reg_write), 64'(0));
    check("rl_in_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rl_first_grant", 64'(req_ready), 64'(3'b001));
    check("rl_first_write_reg", 64'(rf_write_reg), 64'(1));
    check("rl_post_rsp_valid", 64'(rsp_valid), 64'(0));
    next_cycle();
    drive(3'b000, 3'b000, 3'b000, a3(0,0,0), d3('0,'0,'0));
    @(negedge clk);
    check("rl_post2_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rl_idle_ready", 64'(req_ready), 64'(0));
    next_cycle();
    @(negedge clk);
    check("rsp_pending", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Shares the register file's single write port and first read port among NUM_REQ requesters, such as core writeback, a load unit and the debug module. It grants one access per cycle in round-robin order and supports a lock for atomic read-modify-write sequences. It drives the register file control inputs directly and returns read data with the register file's one-cycle read latency. It sits between the requesters and the register file in the single-cycle datapath.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- ID_W, $clog2(NUM_REQ), requester id width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; transfer when valid&ready
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold grant for this requester after this transfer
- req_addr  in  NUM_REQ*ADDR_W  register index, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_W  write data, requester i at slice i
- rsp_valid  out  1  read data valid
- rsp_id  out  ID_W  requester owning rsp_rdata
- rsp_rdata  out  DATA_W  read data
- rf_write_reg  out  ADDR_W  to register file write index
- rf_reg_write  out  1  to register file write enable
- rf_write_data  out  DATA_W  to register file write data
- rf_read_reg1  out  ADDR_W  to register file read index 1
- rf_read_data1  in  DATA_W  from register file read data 1; registered, valid one cycle after index

## Operation
- At most one grant per cycle, either a read or a write. req_ready is one-hot or zero.
- Round-robin: pointer ptr. The granted requester is the first valid one at or after ptr, wrapping modulo NUM_REQ.
  - After a transfer by requester g in IDLE, ptr becomes (g+1) mod NUM_REQ.
- FSM states:
  - IDLE: arbitrate as above. A transfer with req_lock=1 moves to LOCKED with owner = g.
  - LOCKED: only the owner can be granted, and only when it is valid. Other requesters stall.
    - An owner transfer with req_lock=0 returns to IDLE and sets ptr = owner+1.
    - An owner transfer with req_lock=1 stays in LOCKED.
- Write grant: rf_reg_write = 1, rf_write_reg = addr, rf_write_data = wdata. The write commits at the handshake edge.
- Write to index 0: the handshake completes, but rf_reg_write stays 0. x0 is never modified.
- Read grant: rf_read_reg1 = addr. Registered flops set rsp_valid=1 and rsp_id=g on the next cycle; rsp_rdata = rf_read_data1 passthrough.
  - A read of index 0 returns 0 (forced), regardless of register file contents.
- No grant: rf_reg_write = 0; rf_read_reg1 and rf_write_* are don't-care.
  - rf_read_reg1 holds its last value so that register file power stays stable.
- Requesters must hold valid, addr, wdata, we and lock stable until ready. No response backpressure: responses are always accepted.

## Timing
- req_ready and all rf_* outputs are combinational from req_*, ptr and state. No combinational path from rf_read_data1 to req_ready.
- Read latency: handshake in cycle N → rsp_valid in cycle N+1. Back-to-back reads give one response per cycle.
- Write in cycle N, then read of the same index in cycle N+1 returns the new value, because the register file samples the read index after the write edge.
- Write and read of the same index in the same cycle cannot occur (single grant).
- Reset values: ptr=0, state=IDLE, owner=0, rsp_valid=0, rsp_id=0, req_ready=0, rf_reg_write=0.
  - While rst_n is low, req_ready and rf_reg_write are forced to 0.
- Reset asserted mid-lock or with a response pending: the lock is dropped, the response is discarded, and no stale rsp_valid appears after release.

## Structure
- Shared package rf_arb_pkg holds:
  - DATA_W and ADDR_W defaults
  - state enum {IDLE, LOCKED}
  - X0 index constant
- Sub-module rr_arbiter (NUM_REQ, req vector, ptr, enable) → one-hot grant plus encoded index. It is combinational. ptr, state and owner registers stay in rf_port_arbiter.
- Estimated size: 150–250 lines total.

## Test plan
- Reset, then all three requesters issue writes continuously with addrs 1/2/3 and data A/B/C → grants in order 0,1,2,0, each written to the register file in that order.
- Requester 1 writes 0xDEADBEEF to x5, then requester 2 reads x5 in the following cycle → one cycle later rsp_valid=1, rsp_id=2, rsp_rdata=0xDEADBEEF.
- Write 0x1234 to x0, then read x0 → rf_reg_write stays 0 throughout; the read returns 0x00000000.
- Requester 0 reads x7 with lock=1 while requesters 1 and 2 are valid, then requester 0 writes x7 with lock=0 → requesters 1 and 2 receive no ready until the write transfers; the next grant goes to requester 1.
- rst_n is pulsed low in the cycle after a read grant while LOCKED → rsp_valid stays 0 after release, state=IDLE, and the first grant goes to requester 0.
